video_crtc: RTL and testbench
=============================

Name: video_crtc

Overview:
- Programmable 6845-subset CRTC that generates display timing and addresses.
- Drives the video memory/pixel stage downstream with hsync, vsync, display enable, character address (vma) and raster address (vra).
- Advances once per character-clock enable; the CPU programs it through an index/data register pair on the I/O bus.
- Reset defaults give a 40x24 text screen in a 64-char x 312-line frame, so video runs without software setup.

Parameters:
- HT_DEF, 63: R0 horizontal total, in chars minus 1.
- HD_DEF, 40: R1 horizontal displayed chars.
- HSP_DEF, 50: R2 hsync start char.
- SW_DEF, 8'h44: R3 {vsw[7:4], hsw[3:0]}.
- VT_DEF, 38: R4 vertical total, in rows minus 1.
- VA_DEF, 0: R5 vertical adjust, in raster lines.
- VD_DEF, 24: R6 vertical displayed rows.
- VSP_DEF, 30: R7 vsync start row.
- MR_DEF, 7: R9 max raster address.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- cce  in  1  character clock enable; all counters step only on cce
- ce  in  1  CPU clock enable; qualifies bus writes
- sel  in  1  decoded CRTC port select, active-high
- rs  in  1  0 = index register, 1 = data register
- wr  in  1  write strobe, active-low
- rd  in  1  read strobe, active-low
- d  in  8  CPU write data
- q  out  8  CPU read data
- hsync  out  1  horizontal sync, active-high
- vsync  out  1  vertical sync, active-high
- de  out  1  display enable
- vma  out  14  video memory address
- vra  out  3  raster address within row
- cursor  out  1  cursor pixel enable (see Optional Feature)

Behaviour:
- Reset (sync, active-high):
  - hc, rc, vc, adjust counter, ma_row = 0; registers = *_DEF; index = 0.
  - All outputs 0 from the clock after reset is sampled high.
- Bus write (sel && !wr && ce):
  - rs=0 loads index[4:0].
  - rs=1 writes R[index]; index >15 or R8 is ignored.
  - A write takes effect at that clock edge. Counter logic in the same cycle uses the old value.
- Bus read (sel && !rd):
  - rs=1 returns R12–R15 (R12/R14 zero-extended from 6 bits); all others return 8'h00.
  - q is combinational from current register state.
- Horizontal counter hc (8 bit):
  - On cce: if hc == R0, hc <= 0 (end of line); else hc+1.
  - If R0 is written below the current hc, hc counts to 255 and wraps to 0. That wrap also counts as end of line.
- hsync: asserted on cce where hc == R2, held for hsw chars (hsw = 0 means 16).
- hde = hc < R1.
- Raster/row counters, stepped at end of line:
  - rc (5 bit internal) counts 0..R9[4:0].
  - At rc == R9: rc <= 0, vc+1, ma_row <= ma_row + R1 (14-bit wrap).
  - vra = rc[2:0].
- Frame end and vertical adjust:
  - After vc == R4 completes its last raster, enter ADJUST state for R5 lines.
  - R5 = 0 skips ADJUST.
  - At frame end: vc = 0, rc = 0, ma_row = {R12[5:0], R13}. Start address is latched only here.
- State machine: ACTIVE → (vc==R4 && rc==R9 && eol) → ADJUST (if R5 != 0) → FRAME_START (single cce) → ACTIVE.
- vsync:
  - Asserted at the line start where vc == R7 && rc == 0.
  - Held for vsw lines (vsw = 0 means 16).
  - Retriggering while active is ignored.
- vde = vc < R6 && state == ACTIVE.
- Outputs: de = hde && vde; vma = ma_row + hc (14-bit wrap).
- Output timing:
  - hsync/vsync/de/vma/vra are registered and updated on the cce clock. Latency is 1 clock from cce.
  - Outputs are stable between cce pulses.
- Simultaneous events: end of line and end of frame on the same cce resolve as a frame restart; ma_row takes the start address, not +R1.

Optional Feature:
- Macro: CRTC_CURSOR_EN.
- Enabled:
  - R10 {blink[6:5], start[4:0]}, R11 end[4:0], R14/R15 cursor address.
  - cursor = de && vma == {R14[5:0], R15} && start <= rc <= end.
  - blink mode 01 = off; 10/11 = toggle on a 16/32-frame counter.
- Disabled:
  - cursor = 0.
  - R10/R11/R14/R15 writes are ignored and read 0.
  - No blink counter is synthesised.

Decomposition:
- Package video_pkg holds:
  - register index constants (R_HT…R_CURL);
  - vertical state encoding (ACTIVE, ADJUST, FRAME_START);
  - default register values.
- Sub-module crtc_regs holds the index register, the register file, bus write/read decode and reset defaults.
- Counters and sync generation stay in video_crtc.

Test Plan:
- Reset, defaults, 64 cce per line:
  - hsync high for hc 50..53 (4 cce).
  - de high for hc 0..39 on rows 0..23.
  - 312 lines per frame.
- Row addressing:
  - vma = 0..39 on rc 0..7 of row 0; vma = 40 at row 1 start; vra cycles 0..7.
  - Write R12=0x01, R13=0x00 mid-frame → vma = 0x0100 only from the next frame start.
- vsync: asserted at line 240 (row 30, rc 0) for 4 lines. Write R3=0x04 → vsw=0 → vsync lasts 16 lines.
- Horizontal total shrink: write R0=20 while hc=30 → hc runs to 255, wraps, and the following lines are 21 cce long.
- Vertical adjust:
  - R5=4 → frame = 316 lines.
  - Assert reset mid-frame → all outputs 0 next clock; timing restarts at hc=0, vc=0 with default registers.
- Cursor (CRTC_CURSOR_EN):
  - R14=0, R15=5, R10=0x06, R11=0x07 → cursor high only at vma=5 when rc=6..7.
  - With the macro undefined, cursor stays 0 under the same stimulus.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the video_crtc character CRTC: register indices,
// vertical state encoding and power-on register defaults.
package video_pkg;

  localparam int unsigned NREGS = 16;

  localparam logic [3:0] R_HT   = 4'd0;
  localparam logic [3:0] R_HD   = 4'd1;
  localparam logic [3:0] R_HSP  = 4'd2;
  localparam logic [3:0] R_SW   = 4'd3;
  localparam logic [3:0] R_VT   = 4'd4;
  localparam logic [3:0] R_VA   = 4'd5;
  localparam logic [3:0] R_VD   = 4'd6;
  localparam logic [3:0] R_VSP  = 4'd7;
  localparam logic [3:0] R_IL   = 4'd8;
  localparam logic [3:0] R_MR   = 4'd9;
  localparam logic [3:0] R_CURS = 4'd10;
  localparam logic [3:0] R_CURE = 4'd11;
  localparam logic [3:0] R_SAH  = 4'd12;
  localparam logic [3:0] R_SAL  = 4'd13;
  localparam logic [3:0] R_CURH = 4'd14;
  localparam logic [3:0] R_CURL = 4'd15;

  typedef enum logic [1:0] {
    ACTIVE      = 2'd0,
    ADJUST      = 2'd1,
    FRAME_START = 2'd2
  } vstate_e;

  localparam logic [7:0] DEF_HT  = 8'd63;
  localparam logic [7:0] DEF_HD  = 8'd40;
  localparam logic [7:0] DEF_HSP = 8'd50;
  localparam logic [7:0] DEF_SW  = 8'h44;
  localparam logic [7:0] DEF_VT  = 8'd38;
  localparam logic [7:0] DEF_VA  = 8'd0;
  localparam logic [7:0] DEF_VD  = 8'd24;
  localparam logic [7:0] DEF_VSP = 8'd30;
  localparam logic [7:0] DEF_MR  = 8'd7;

  // A programmed sync width of zero stands for the full 16 units.
  function automatic logic [4:0] sync_width(input logic [3:0] w);
    return (w == 4'd0) ? 5'd16 : {1'b0, w};
  endfunction

endpackage

// File: rtl/crtc_regs.sv
// CPU-facing index/data register pair and register file of video_crtc.
// Cursor registers R10/R11/R14/R15 exist only when CRTC_CURSOR_EN is defined.
module crtc_regs
  import video_pkg::*;
#(
  parameter logic [7:0] HT_DEF  = DEF_HT,
  parameter logic [7:0] HD_DEF  = DEF_HD,
  parameter logic [7:0] HSP_DEF = DEF_HSP,
  parameter logic [7:0] SW_DEF  = DEF_SW,
  parameter logic [7:0] VT_DEF  = DEF_VT,
  parameter logic [7:0] VA_DEF  = DEF_VA,
  parameter logic [7:0] VD_DEF  = DEF_VD,
  parameter logic [7:0] VSP_DEF = DEF_VSP,
  parameter logic [7:0] MR_DEF  = DEF_MR
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        ce_i,
  input  logic        sel_i,
  input  logic        rs_i,
  input  logic        wr_i,
  input  logic        rd_i,
  input  logic [7:0]  d_i,
  output logic [7:0]  q_o,
  output logic [7:0]  ht_o,
  output logic [7:0]  hd_o,
  output logic [7:0]  hsp_o,
  output logic [7:0]  sw_o,
  output logic [6:0]  vt_o,
  output logic [4:0]  va_o,
  output logic [6:0]  vd_o,
  output logic [6:0]  vsp_o,
  output logic [4:0]  mr_o,
`ifdef CRTC_CURSOR_EN
  output logic [6:0]  cur_cfg_o,
  output logic [4:0]  cur_end_o,
  output logic [13:0] cur_addr_o,
`endif
  output logic [13:0] start_o
);

  localparam logic [NREGS-1:0][7:0] REGS_RST = {
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, MR_DEF, 8'h00,
    VSP_DEF, VD_DEF, VA_DEF, VT_DEF, SW_DEF, HSP_DEF, HD_DEF, HT_DEF
  };

  logic [4:0]              index_q, index_d;
  logic [NREGS-1:0][7:0]   regs_q, regs_d;
  logic                    wr_en;

  function automatic logic writable(input logic [4:0] idx);
    logic ok;
    ok = !idx[4] && (idx[3:0] != R_IL);
`ifndef CRTC_CURSOR_EN
    if (idx[3:0] inside {R_CURS, R_CURE, R_CURH, R_CURL}) ok = 1'b0;
`endif
    return ok;
  endfunction

  assign wr_en = sel_i && !wr_i && ce_i;

  always_comb begin
    index_d = index_q;
    regs_d  = regs_q;
    if (wr_en) begin
      if (!rs_i) begin
        index_d = d_i[4:0];
      end else if (writable(index_q)) begin
        // High address bytes only hold six bits.
        if (index_q[3:0] == R_SAH || index_q[3:0] == R_CURH)
          regs_d[index_q[3:0]] = {2'b00, d_i[5:0]};
        else
          regs_d[index_q[3:0]] = d_i;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      index_q <= '0;
      regs_q  <= REGS_RST;
    end else begin
      index_q <= index_d;
      regs_q  <= regs_d;
    end
  end

  always_comb begin
    q_o = 8'h00;
    if (sel_i && !rd_i && rs_i && !index_q[4]) begin
      case (index_q[3:0])
        R_SAH, R_SAL:   q_o = regs_q[index_q[3:0]];
`ifdef CRTC_CURSOR_EN
        R_CURH, R_CURL: q_o = regs_q[index_q[3:0]];
`endif
        default:        q_o = 8'h00;
      endcase
    end
  end

  assign ht_o    = regs_q[R_HT];
  assign hd_o    = regs_q[R_HD];
  assign hsp_o   = regs_q[R_HSP];
  assign sw_o    = regs_q[R_SW];
  assign vt_o    = regs_q[R_VT][6:0];
  assign va_o    = regs_q[R_VA][4:0];
  assign vd_o    = regs_q[R_VD][6:0];
  assign vsp_o   = regs_q[R_VSP][6:0];
  assign mr_o    = regs_q[R_MR][4:0];
  assign start_o = {regs_q[R_SAH][5:0], regs_q[R_SAL]};
`ifdef CRTC_CURSOR_EN
  assign cur_cfg_o  = regs_q[R_CURS][6:0];
  assign cur_end_o  = regs_q[R_CURE][4:0];
  assign cur_addr_o = {regs_q[R_CURH][5:0], regs_q[R_CURL]};
`endif

endmodule

// File: rtl/video_crtc.sv
// 6845-subset CRTC: character/raster/row counters, sync generation and video
// addressing. Hardware cursor and blink are built only with CRTC_CURSOR_EN.
module video_crtc
  import video_pkg::*;
#(
  parameter logic [7:0] HT_DEF  = DEF_HT,
  parameter logic [7:0] HD_DEF  = DEF_HD,
  parameter logic [7:0] HSP_DEF = DEF_HSP,
  parameter logic [7:0] SW_DEF  = DEF_SW,
  parameter logic [7:0] VT_DEF  = DEF_VT,
  parameter logic [7:0] VA_DEF  = DEF_VA,
  parameter logic [7:0] VD_DEF  = DEF_VD,
  parameter logic [7:0] VSP_DEF = DEF_VSP,
  parameter logic [7:0] MR_DEF  = DEF_MR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cce,
  input  logic        ce,
  input  logic        sel,
  input  logic        rs,
  input  logic        wr,
  input  logic        rd,
  input  logic [7:0]  d,
  output logic [7:0]  q,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [13:0] vma,
  output logic [2:0]  vra,
  output logic        cursor
);

  logic [7:0]  ht, hd, hsp, sw;
  logic [6:0]  vt, vd, vsp;
  logic [4:0]  va, mr;
  logic [13:0] start_addr;
`ifdef CRTC_CURSOR_EN
  logic [6:0]  cur_cfg;
  logic [4:0]  cur_end;
  logic [13:0] cur_addr;
`endif

  crtc_regs #(
    .HT_DEF (HT_DEF),  .HD_DEF (HD_DEF),  .HSP_DEF(HSP_DEF),
    .SW_DEF (SW_DEF),  .VT_DEF (VT_DEF),  .VA_DEF (VA_DEF),
    .VD_DEF (VD_DEF),  .VSP_DEF(VSP_DEF), .MR_DEF (MR_DEF)
  ) u_regs (
    .clock_i   (clock),
    .reset_i   (reset),
    .ce_i      (ce),
    .sel_i     (sel),
    .rs_i      (rs),
    .wr_i      (wr),
    .rd_i      (rd),
    .d_i       (d),
    .q_o       (q),
    .ht_o      (ht),
    .hd_o      (hd),
    .hsp_o     (hsp),
    .sw_o      (sw),
    .vt_o      (vt),
    .va_o      (va),
    .vd_o      (vd),
    .vsp_o     (vsp),
    .mr_o      (mr),
`ifdef CRTC_CURSOR_EN
    .cur_cfg_o (cur_cfg),
    .cur_end_o (cur_end),
    .cur_addr_o(cur_addr),
`endif
    .start_o   (start_addr)
  );

  vstate_e     state_q, state_d;
  logic [7:0]  hc_q, hc_d;
  logic [4:0]  rc_q, rc_d;
  logic [6:0]  vc_q, vc_d;
  logic [4:0]  adj_q, adj_d;
  logic [13:0] ma_row_q, ma_row_d;
  logic [4:0]  hs_rem_q, hs_rem_d;
  logic [4:0]  vs_rem_q, vs_rem_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, cursor_q, cursor_d;
  logic [13:0] vma_q, vma_d;
  logic [2:0]  vra_q, vra_d;

  logic eol, row_end, vs_trig;

  // hc == 255 also ends the line, so shrinking R0 below hc cannot lock up.
  assign eol     = (hc_q == ht) || (hc_q == 8'hFF);
  assign row_end = (rc_q == mr);
  assign vs_trig = (state_q != ADJUST) && (vc_q == vsp) && (rc_q == 5'd0);

  always_comb begin
    state_d  = state_q;
    hc_d     = hc_q;
    rc_d     = rc_q;
    vc_d     = vc_q;
    adj_d    = adj_q;
    ma_row_d = ma_row_q;
    if (cce) begin
      hc_d = eol ? 8'd0 : hc_q + 8'd1;
      if (state_q == FRAME_START) state_d = ACTIVE;
      if (eol) begin
        if (state_q == ADJUST) begin
          if (adj_q + 5'd1 == va) begin
            state_d  = FRAME_START;
            vc_d     = '0;
            rc_d     = '0;
            ma_row_d = start_addr;
          end else begin
            adj_d = adj_q + 5'd1;
          end
        end else if (row_end && vc_q == vt) begin
          // Frame end wins over row advance: ma_row reloads, no +R1.
          if (va != 5'd0) begin
            state_d = ADJUST;
            adj_d   = '0;
            rc_d    = '0;
          end else begin
            state_d  = FRAME_START;
            vc_d     = '0;
            rc_d     = '0;
            ma_row_d = start_addr;
          end
        end else if (row_end) begin
          rc_d     = '0;
          vc_d     = vc_q + 7'd1;
          ma_row_d = ma_row_q + {6'b0, hd};
        end else begin
          rc_d = rc_q + 5'd1;
        end
      end
    end
  end

  always_comb begin
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    de_d     = de_q;
    vma_d    = vma_q;
    vra_d    = vra_q;
    hs_rem_d = hs_rem_q;
    vs_rem_d = vs_rem_q;
    if (cce) begin
      if (hc_q == hsp) begin
        hsync_d  = 1'b1;
        hs_rem_d = sync_width(sw[3:0]) - 5'd1;
      end else if (hs_rem_q != 5'd0) begin
        hsync_d  = 1'b1;
        hs_rem_d = hs_rem_q - 5'd1;
      end else begin
        hsync_d = 1'b0;
      end
      // Vertical sync is evaluated once per line, at its first character.
      if (hc_q == 8'd0) begin
        if (vsync_q && vs_rem_q != 5'd0) begin
          vs_rem_d = vs_rem_q - 5'd1;
        end else if (vs_trig) begin
          vsync_d  = 1'b1;
          vs_rem_d = sync_width(sw[7:4]) - 5'd1;
        end else begin
          vsync_d = 1'b0;
        end
      end
      de_d  = (hc_q < hd) && (vc_q < vd) && (state_q == ACTIVE);
      vma_d = ma_row_q + {6'b0, hc_q};
      vra_d = rc_q[2:0];
    end
  end

`ifdef CRTC_CURSOR_EN
  logic [4:0] blink_q, blink_d;
  logic       cur_vis;

  assign blink_d = (cce && state_q == FRAME_START) ? blink_q + 5'd1 : blink_q;

  always_comb begin
    case (cur_cfg[6:5])
      2'b00:   cur_vis = 1'b1;
      2'b01:   cur_vis = 1'b0;
      2'b10:   cur_vis = !blink_q[3];
      default: cur_vis = !blink_q[4];
    endcase
  end

  always_comb begin
    cursor_d = cursor_q;
    if (cce)
      cursor_d = de_d && cur_vis && (vma_d == cur_addr) &&
                 (rc_q >= cur_cfg[4:0]) && (rc_q <= cur_end);
  end

  always_ff @(posedge clock) begin
    if (reset) blink_q <= '0;
    else       blink_q <= blink_d;
  end
`else
  assign cursor_d = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ACTIVE;
      hc_q     <= '0;
      rc_q     <= '0;
      vc_q     <= '0;
      adj_q    <= '0;
      ma_row_q <= '0;
      hs_rem_q <= '0;
      vs_rem_q <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      de_q     <= 1'b0;
      cursor_q <= 1'b0;
      vma_q    <= '0;
      vra_q    <= '0;
    end else begin
      state_q  <= state_d;
      hc_q     <= hc_d;
      rc_q     <= rc_d;
      vc_q     <= vc_d;
      adj_q    <= adj_d;
      ma_row_q <= ma_row_d;
      hs_rem_q <= hs_rem_d;
      vs_rem_q <= vs_rem_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      cursor_q <= cursor_d;
      vma_q    <= vma_d;
      vra_q    <= vra_d;
    end
  end

  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign de     = de_q;
  assign vma    = vma_q;
  assign vra    = vra_q;
  assign cursor = cursor_q;

endmodule

// File: tb/tb_video_crtc.sv
// Directed bench for video_crtc: default timing, addressing, syncs, R0 shrink,
// vertical adjust, reset, register readback and cursor.
module tb_video_crtc;

`ifdef CRTC_CURSOR_EN
  localparam bit CUR_EN = 1'b1;
`else
  localparam bit CUR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, cce, ce, sel, rs, wr, rd;
  logic [7:0]  d, q;
  logic        hsync, vsync, de, cursor;
  logic [13:0] vma;
  logic [2:0]  vra;

  int checks = 0;
  int errors = 0;

  video_crtc dut (
    .clock(clock), .reset(reset), .cce(cce), .ce(ce), .sel(sel), .rs(rs),
    .wr(wr), .rd(rd), .d(d), .q(q), .hsync(hsync), .vsync(vsync), .de(de),
    .vma(vma), .vra(vra), .cursor(cursor)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cce = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic rsel, input logic [7:0] data);
    sel = 1'b1; rs = rsel; wr = 1'b0; ce = 1'b1; d = data;
    step();
    sel = 1'b0; rs = 1'b0; wr = 1'b1; ce = 1'b0; d = 8'h00;
  endtask

  task automatic set_reg(input logic [4:0] idx, input logic [7:0] val);
    bus_write(1'b0, {3'b000, idx});
    bus_write(1'b1, val);
  endtask

  task automatic test_reset();
    reset = 1'b1; cce = 1'b1;
    step(); step();
    checks++; if (vma !== 14'd0) begin errors++; $display("FAIL reset_vma: got %0d want 0", vma); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b want 0", de); end
    checks++; if ({hsync, vsync, vra, cursor} !== 6'd0) begin errors++;
      $display("FAIL reset_misc: hs=%b vs=%b vra=%0d cur=%b want all 0", hsync, vsync, vra, cursor); end
    reset = 1'b0; cce = 1'b0;
    step(); step(); step();
    checks++; if ({de, vma} !== 15'd0) begin errors++;
      $display("FAIL hold_without_cce: de=%b vma=%0d want 0/0", de, vma); end
  endtask

  task automatic test_defaults();
    int mm_hs = 0, mm_de = 0, mm_vma = 0, mm_vra = 0, mm_vs = 0;
    int f_hs = -1, f_de = -1, f_vma = -1, f_vra = -1, f_vs = -1;
    cce = 1'b1;
    for (int k = 1; k <= 312*64 + 2; k++) begin
      int p, lp, hcx, line, row;
      logic e_hs, e_de, e_vs;
      logic [13:0] e_vma;
      step();
      p = k - 1;
      lp = (p >= 312*64) ? p - 312*64 : p;
      hcx = lp % 64; line = lp / 64; row = line / 8;
      e_hs = (hcx >= 50) && (hcx <= 53);
      e_de = (hcx < 40) && (row < 24) && (p != 312*64);
      e_vs = (line >= 240) && (line <= 243);
      e_vma = 14'(row*40 + hcx);
      if (hsync !== e_hs) begin if (mm_hs == 0) f_hs = p; mm_hs++; end
      if (de !== e_de) begin if (mm_de == 0) f_de = p; mm_de++; end
      if (vma !== e_vma) begin if (mm_vma == 0) f_vma = p; mm_vma++; end
      if (vra !== 3'(line % 8)) begin if (mm_vra == 0) f_vra = p; mm_vra++; end
      if (vsync !== e_vs) begin if (mm_vs == 0) f_vs = p; mm_vs++; end
    end
    checks++; if (mm_hs != 0) begin errors++; $display("FAIL default_hsync: %0d bad chars (first %0d) want 0", mm_hs, f_hs); end
    checks++; if (mm_de != 0) begin errors++; $display("FAIL default_de: %0d bad chars (first %0d) want 0", mm_de, f_de); end
    checks++; if (mm_vma != 0) begin errors++; $display("FAIL default_vma_312_lines: %0d bad chars (first %0d) want 0", mm_vma, f_vma); end
    checks++; if (mm_vra != 0) begin errors++; $display("FAIL default_vra: %0d bad chars (first %0d) want 0", mm_vra, f_vra); end
    checks++; if (mm_vs != 0) begin errors++; $display("FAIL default_vsync: %0d bad chars (first %0d) want 0", mm_vs, f_vs); end
  endtask

  task automatic test_vsync_width();
    int mm = 0, f = -1;
    do_reset();
    set_reg(5'd3, 8'h04);
    set_reg(5'd7, 8'd1);
    cce = 1'b1;
    for (int k = 1; k <= 26*64; k++) begin
      int line;
      step();
      line = (k - 1) / 64;
      if (vsync !== ((line >= 8) && (line < 24))) begin if (mm == 0) f = k - 1; mm++; end
    end
    checks++; if (mm != 0) begin errors++; $display("FAIL vsync_16_lines: %0d bad chars (first %0d) want 0", mm, f); end
  endtask

  task automatic test_hshrink();
    do_reset();
    cce = 1'b1;
    for (int k = 1; k <= 30; k++) step();
    bus_write(1'b1, 8'd20);
    for (int k = 32; k <= 299; k++) begin
      step();
      if (k == 256) begin
        checks++; if (vma !== 14'd255 || vra !== 3'd0 || de !== 1'b0) begin errors++;
          $display("FAIL shrink_hc255: vma=%0d vra=%0d de=%b want 255/0/0", vma, vra, de); end
      end
      if (k == 257) begin
        checks++; if (vma !== 14'd0 || vra !== 3'd1) begin errors++;
          $display("FAIL shrink_wrap: vma=%0d vra=%0d want 0/1", vma, vra); end
      end
      if (k == 277) begin
        checks++; if (vma !== 14'd20 || vra !== 3'd1) begin errors++;
          $display("FAIL shrink_line_end: vma=%0d vra=%0d want 20/1", vma, vra); end
      end
      if (k == 278 || k == 299) begin
        checks++; if (vma !== 14'd0 || vra !== ((k == 278) ? 3'd2 : 3'd3)) begin errors++;
          $display("FAIL shrink_21_char_line at %0d: vma=%0d vra=%0d", k, vma, vra); end
      end
    end
  endtask

  task automatic test_start_addr();
    do_reset();
    set_reg(5'd4, 8'd1);
    cce = 1'b1;
    for (int k = 1; k <= 300; k++) step();
    set_reg(5'd12, 8'hC1);
    set_reg(5'd13, 8'h00);
    sel = 1'b1; rs = 1'b1; rd = 1'b0; #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL read_r13: got %h want 00", q); end
    sel = 1'b0; rd = 1'b1; rs = 1'b0;
    bus_write(1'b0, 8'd12);
    sel = 1'b1; rs = 1'b1; rd = 1'b0; #1;
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL read_r12_masked: got %h want 01", q); end
    sel = 1'b0; rd = 1'b1; rs = 1'b0;
    bus_write(1'b0, 8'd0);
    sel = 1'b1; rs = 1'b1; rd = 1'b0; #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL read_r0_zero: got %h want 00", q); end
    sel = 1'b0; rd = 1'b1; rs = 1'b0;
    for (int k = 307; k <= 1026; k++) begin
      step();
      if (k == 513) begin
        checks++; if (vma !== 14'd40 || vra !== 3'd0) begin errors++;
          $display("FAIL row1_start: vma=%0d vra=%0d want 40/0", vma, vra); end
      end
      if (k == 1024) begin
        checks++; if (vma !== 14'd103) begin errors++; $display("FAIL start_not_early: vma=%0d want 103", vma); end
      end
      if (k == 1025) begin
        checks++; if (vma !== 14'h0100 || de !== 1'b0) begin errors++;
          $display("FAIL new_frame_start_addr: vma=%h de=%b want 0100/0", vma, de); end
      end
      if (k == 1026) begin
        checks++; if (vma !== 14'h0101 || de !== 1'b1) begin errors++;
          $display("FAIL new_frame_next: vma=%h de=%b want 0101/1", vma, de); end
      end
    end
  endtask

  task automatic test_vadjust();
    int mm = 0, f = -1;
    do_reset();
    set_reg(5'd5, 8'd4);
    cce = 1'b1;
    for (int k = 1; k <= 316*64 + 2; k++) begin
      step();
      if (k > 312*64 && k <= 316*64 + 1 && de !== 1'b0) begin if (mm == 0) f = k - 1; mm++; end
      if (k == 312*64) begin
        checks++; if (vma !== 14'd1583 || vra !== 3'd7) begin errors++;
          $display("FAIL adj_last_active: vma=%0d vra=%0d want 1583/7", vma, vra); end
      end
      if (k == 312*64 + 1) begin
        checks++; if (vra !== 3'd0 || de !== 1'b0) begin errors++;
          $display("FAIL adj_enter: vra=%0d de=%b want 0/0", vra, de); end
      end
      if (k == 316*64 + 1) begin
        checks++; if (vma !== 14'd0 || vra !== 3'd0) begin errors++;
          $display("FAIL adj_316_restart: vma=%0d vra=%0d want 0/0", vma, vra); end
      end
      if (k == 316*64 + 2) begin
        checks++; if (vma !== 14'd1 || de !== 1'b1) begin errors++;
          $display("FAIL adj_after_restart: vma=%0d de=%b want 1/1", vma, de); end
      end
    end
    checks++; if (mm != 0) begin errors++; $display("FAIL adj_blank: %0d chars with de (first %0d) want 0", mm, f); end
  endtask

  task automatic test_reset_mid();
    int mm = 0, f = -1;
    bit seen = 1'b0;
    set_reg(5'd2, 8'd10);
    for (int k = 0; k < 200 && !seen; k++) begin
      step();
      if (hsync === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL mid_hsync_timeout: hsync=%b want 1 within 200 cycles", hsync); end
    reset = 1'b1;
    step();
    checks++; if ({hsync, vsync, de, vma, vra, cursor} !== 21'd0) begin errors++;
      $display("FAIL mid_reset_outputs: hs=%b vs=%b de=%b vma=%0d vra=%0d cur=%b want 0", hsync, vsync, de, vma, vra, cursor); end
    reset = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      int hcx;
      step();
      hcx = k - 1;
      if (k == 1) begin
        checks++; if (vma !== 14'd0 || de !== 1'b1 || vra !== 3'd0) begin errors++;
          $display("FAIL mid_restart: vma=%0d de=%b vra=%0d want 0/1/0", vma, de, vra); end
      end
      if (hsync !== ((hcx >= 50) && (hcx <= 53))) begin if (mm == 0) f = hcx; mm++; end
    end
    checks++; if (mm != 0) begin errors++; $display("FAIL mid_default_r2: %0d bad chars (first hc %0d) want 0", mm, f); end
  endtask

  task automatic test_cursor();
    int mm = 0, f = -1;
    do_reset();
    set_reg(5'd14, 8'd0);
    set_reg(5'd15, 8'd5);
    set_reg(5'd10, 8'h06);
    set_reg(5'd11, 8'h07);
    bus_write(1'b0, 8'd15);
    sel = 1'b1; rs = 1'b1; rd = 1'b0; #1;
    checks++; if (q !== (CUR_EN ? 8'd5 : 8'd0)) begin errors++; $display("FAIL read_r15: got %0d want %0d", q, CUR_EN ? 5 : 0); end
    sel = 1'b0; rd = 1'b1; rs = 1'b0;
    cce = 1'b1;
    for (int k = 1; k <= 9*64; k++) begin
      int p, line;
      logic e_cur;
      step();
      p = k - 1; line = p / 64;
      e_cur = CUR_EN && (line < 8) && (line >= 6) && (p % 64 == 5);
      if (cursor !== e_cur) begin if (mm == 0) f = p; mm++; end
      if (k == 6*64 + 6) begin
        checks++; if (cursor !== CUR_EN) begin errors++; $display("FAIL cursor_hit: got %b want %b", cursor, CUR_EN); end
      end
    end
    checks++; if (mm != 0) begin errors++; $display("FAIL cursor_window: %0d bad chars (first %0d) want 0", mm, f); end
  endtask

  initial begin
    reset = 1'b1; cce = 1'b0; ce = 1'b0; sel = 1'b0; rs = 1'b0;
    wr = 1'b1; rd = 1'b1; d = 8'h00;
    test_reset();
    test_defaults();
    test_vsync_width();
    test_hshrink();
    test_start_addr();
    test_vadjust();
    test_reset_mid();
    test_cursor();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
